uart_transmit_fifo: RTL and testbench
=====================================

Name: uart_transmit_fifo

Overview:
- 8N1 UART transmitter with a small input FIFO. It is the transmit-side counterpart of the existing UART receiver on the same 25 MHz board clock.
- Game logic pushes bytes through a valid/ready handshake; the block serialises them LSB-first on one TX pin.
- Purpose: echo keypresses and report score and debug bytes back to the host terminal.

Parameters:
- CLKS_PER_BIT, default 217: clock cycles per bit (115200 baud at 25 MHz). Legal range is 2 or more.
- FIFO_DEPTH, default 4: number of FIFO entries. Must be a power of 2, 2 or more.

Ports:
- i_CLK  in  1  system clock.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_tx_valid  in  1  producer presents a byte this cycle.
- i_tx_byte  in  8  byte to send; sampled when i_tx_valid and o_tx_ready are both 1.
- o_tx_ready  out  1  FIFO can accept a byte (count < FIFO_DEPTH).
- o_tx_serial  out  1  UART TX line; idles high.
- o_tx_active  out  1  high while a frame (start, data or stop bit) is on the line.
- o_tx_done  out  1  one-cycle pulse when a frame's stop bit completes.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (async assert, sync release):
  - o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_fifo_count=0, o_tx_ready=1.
  - FIFO pointers cleared, state IDLE, baud and bit counters 0.
- Reset mid-frame aborts the frame: the line goes high immediately and queued bytes are discarded.
- FIFO:
  - Write occurs when i_tx_valid and o_tx_ready are both 1.
  - i_tx_valid while full is ignored: the byte is dropped and the producer must hold it.
  - o_tx_ready is combinational from the registered count.
  - Write and pop in the same cycle leave the count unchanged and are legal when full (pop frees space) and when count=1.
  - No write-through: a byte written into an empty FIFO is popped no earlier than the next cycle.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Serializer FSM: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - o_tx_serial=1, o_tx_active=0.
  - If count>0: pop the head into the shift register, clear the baud counter, go to START.
- START:
  - o_tx_serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - o_tx_serial=shift[bit index] for CLKS_PER_BIT cycles each, LSB first.
  - After bit 7's last cycle, go to STOP.
- STOP:
  - o_tx_serial=1 for CLKS_PER_BIT cycles.
  - On the last stop cycle, assert o_tx_done for the next cycle.
  - If count>0 on that last cycle: pop and go directly to START, with no idle gap.
  - Otherwise go to IDLE.
- o_tx_active is 1 in START, DATA and STOP.
- Latency:
  - Write accepted at edge N into an empty FIFO with FSM IDLE: count=1 after edge N; pop at edge N+1; o_tx_serial falls after edge N+2.
- Timing:
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
  - Continuous streaming frames are spaced exactly 10*CLKS_PER_BIT cycles apart.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - No off-by-one permitted.
- i_tx_byte is captured at write time; later changes have no effect.

Test Plan:
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: write 0x77 into an empty FIFO.
  - Response: o_tx_serial falls two edges later and carries 0,1,1,1,0,1,1,1,0,1, each value held 4 cycles.
  - o_tx_active is high for 40 cycles; one o_tx_done pulse follows; the line then idles high.
- Overflow, depth 4:
  - Stimulus: i_tx_valid held high for 6 consecutive cycles with bytes 0x01..0x06.
  - Response: the first byte is popped; o_tx_ready drops when count=4.
  - Exactly 5 bytes (0x01..0x05) are transmitted in order; 0x06 is never sent.
- Back-to-back:
  - Stimulus: preload 3 bytes.
  - Response: start bits fall at cycles T, T+40 and T+80 (CLKS_PER_BIT=4), with no high gap beyond the stop bits.
  - Three o_tx_done pulses are spaced 40 cycles apart.
- Simultaneous push/pop:
  - Stimulus: FIFO full, then a write in the same cycle as the STOP-end pop.
  - Response: the write is accepted and count stays at 4.
- Reset mid-frame:
  - Stimulus: assert i_RST_N=0 during data bit 3 with 2 bytes queued.
  - Response: o_tx_serial=1 without waiting for a clock edge; count=0; o_tx_active=0.
  - After release, nothing is transmitted until a new write.
- Default parameters:
  - Stimulus: write 0x73 with CLKS_PER_BIT=217.
  - Response: each bit lasts exactly 217 cycles; the frame lasts 2170 cycles.

Source files
------------

// File: rtl/uart_transmit_fifo.sv
// 8N1 UART transmitter fed by a small valid/ready byte FIFO.
// Bytes leave LSB-first. Back-to-back frames have no idle gap between them.
module uart_transmit_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RST_N,
    input  logic                          i_tx_valid,
    input  logic [7:0]                    i_tx_byte,
    output logic                          o_tx_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_active,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              serial_q, serial_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic              baud_last, pop, push;

    assign baud_last = (baud_q == BAUD_LAST);
    assign pop  = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && baud_last));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept that cycle.
    assign o_tx_ready = (count_q != DEPTH_C) || pop;
    assign push = i_tx_valid && o_tx_ready;

    assign o_tx_serial  = serial_q;
    assign o_tx_active  = active_q;
    assign o_tx_done    = done_q;
    assign o_fifo_count = count_q;

    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_tx_byte;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = 1'b1;
        active_d = (state_q != IDLE);
        done_d   = 1'b0;
        // Line outputs follow the state one cycle later, so every bit keeps its full width.
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                serial_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                serial_d = shift_q[bit_q];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                serial_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    if (pop) begin
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_transmit_fifo.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes and compares them.
// Instance 0 runs at 4 clocks/bit; instance 1 uses the default parameters.
module tb_uart_transmit_fifo;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2];
    logic       valid   [2];
    logic [7:0] tx_byte [2];
    logic       ready   [2];
    logic       ser     [2];
    logic       act     [2];
    logic       dn      [2];
    logic [2:0] cnt     [2];

    uart_transmit_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_fast (
        .i_CLK(clk), .i_RST_N(rst_n[0]), .i_tx_valid(valid[0]), .i_tx_byte(tx_byte[0]),
        .o_tx_ready(ready[0]), .o_tx_serial(ser[0]), .o_tx_active(act[0]),
        .o_tx_done(dn[0]), .o_fifo_count(cnt[0])
    );

    uart_transmit_fifo dut_def (
        .i_CLK(clk), .i_RST_N(rst_n[1]), .i_tx_valid(valid[1]), .i_tx_byte(tx_byte[1]),
        .o_tx_ready(ready[1]), .o_tx_serial(ser[1]), .o_tx_active(act[1]),
        .o_tx_done(dn[1]), .o_fifo_count(cnt[1])
    );

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t exp_qa[$];
    exp_t exp_qb[$];

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, ecount);
        end
    endtask

    task automatic expect_frame(input int k, input logic [7:0] b, input int start);
        exp_t e;
        e.b = b;
        e.start = start;
        if (k == 0) exp_qa.push_back(e);
        else        exp_qb.push_back(e);
    endtask

    // Line monitor: samples on the falling edge, decodes one 10-bit frame at a time.
    int         mon_pos [2] = '{-1, -1};
    int         mon_start [2];
    int         flags [2];
    logic [9:0] bits [2];
    int         m_cpb, m_bi, m_ph;

    task automatic end_frame(input int k);
        exp_t e;
        int   have;
        have = (k == 0) ? exp_qa.size() : exp_qb.size();
        if (have == 0) begin
            chk($sformatf("unexpected_frame%0d", k), int'(bits[k][8:1]), -1);
        end else begin
            if (k == 0) e = exp_qa.pop_front();
            else        e = exp_qb.pop_front();
            $display("frame dut%0d byte=%02h start_edge=%0d", k, bits[k][8:1], mon_start[k]);
            chk("frame_byte", int'(bits[k][8:1]), int'(e.b));
            chk("frame_start_edge", mon_start[k], e.start);
            chk("frame_shape", flags[k], 0);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_cpb = (k == 0) ? 4 : 217;
            if (rst_n[k] !== 1'b1) begin
                mon_pos[k] = -1;
            end else begin
                if (mon_pos[k] < 0) begin
                    if (ser[k] === 1'b0) begin
                        mon_pos[k]   = 0;
                        mon_start[k] = ecount;
                        flags[k]     = 0;
                    end else if (dn[k] !== 1'b0) begin
                        chk($sformatf("stray_done%0d", k), 1, 0);
                    end
                end
                if (mon_pos[k] >= 0) begin
                    m_bi = mon_pos[k] / m_cpb;
                    m_ph = mon_pos[k] % m_cpb;
                    if (m_ph == 0) bits[k][m_bi] = ser[k];
                    else if (ser[k] !== bits[k][m_bi]) flags[k] |= 1;
                    if (act[k] !== 1'b1) flags[k] |= 8;
                    if (dn[k] !== (mon_pos[k] == 10 * m_cpb - 1)) flags[k] |= 16;
                    mon_pos[k]++;
                    if (mon_pos[k] == 10 * m_cpb) begin
                        if (bits[k][9] !== 1'b1) flags[k] |= 4;
                        end_frame(k);
                        mon_pos[k] = -1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k, input int limit);
        int i = 0;
        while ((((k == 0) ? exp_qa.size() : exp_qb.size()) != 0 || mon_pos[k] >= 0) && i < limit) begin
            @(posedge clk);
            i++;
        end
        if (i >= limit) chk("drain_timeout", 1, 0);
        #1;
        chk("idle_active", int'(act[k]), 0);
        chk("idle_serial", int'(ser[k]), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b2b [3];
        b2b = '{8'hA5, 8'h3C, 8'hF0};
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; valid[k] = 1'b0; tx_byte[k] = 8'h00;
        end
        repeat (3) tick();
        chk("rst_serial", int'(ser[0]), 1);
        chk("rst_active", int'(act[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_count", int'(cnt[0]), 0);
        chk("rst_ready", int'(ready[0]), 1);
        chk("rst_count_def", int'(cnt[1]), 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        tick();

        // Single byte 0x77
        valid[0] = 1'b1; tx_byte[0] = 8'h77;
        tick();
        n = ecount;
        valid[0] = 1'b0; tx_byte[0] = 8'hFF;
        expect_frame(0, 8'h77, n + 2);
        chk("single_count_after_write", int'(cnt[0]), 1);
        tick();
        chk("single_count_after_pop", int'(cnt[0]), 0);
        chk("single_line_still_high", int'(ser[0]), 1);
        tick();
        chk("single_line_falls", int'(ser[0]), 0);
        drain(0, 200);

        // Overflow: six cycles of valid, only five fit
        valid[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_byte[0] = 8'(i + 1);
            tick();
            if (i == 0) n = ecount;
            if (i == 4) begin
                chk("ovf_count_full", int'(cnt[0]), 4);
                chk("ovf_ready_low", int'(ready[0]), 0);
            end
        end
        valid[0] = 1'b0;
        chk("ovf_count_hold", int'(cnt[0]), 4);
        for (int i = 0; i < 5; i++) expect_frame(0, 8'(i + 1), n + 2 + 40 * i);
        drain(0, 400);

        // Back-to-back frames
        valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_byte[0] = b2b[i];
            tick();
            if (i == 0) n = ecount;
        end
        valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) expect_frame(0, b2b[i], n + 2 + 40 * i);
        drain(0, 300);

        // Write while full in the same cycle as the stop-end pop
        valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_byte[0] = 8'(8'h11 * (i + 1));
            tick();
            if (i == 0) n = ecount;
        end
        valid[0] = 1'b0;
        chk("pp_count_full", int'(cnt[0]), 4);
        repeat (35) tick();
        chk("pp_ready_before_pop", int'(ready[0]), 0);
        tick();
        chk("pp_ready_on_pop", int'(ready[0]), 1);
        valid[0] = 1'b1; tx_byte[0] = 8'h66;
        tick();
        valid[0] = 1'b0;
        chk("pp_count_stays", int'(cnt[0]), 4);
        for (int i = 0; i < 6; i++) expect_frame(0, 8'(8'h11 * (i + 1)), n + 2 + 40 * i);
        drain(0, 400);

        // Reset during data bit 3 with two bytes still queued
        valid[0] = 1'b1;
        tx_byte[0] = 8'h00; tick(); n = ecount;
        tx_byte[0] = 8'h81; tick();
        tx_byte[0] = 8'h42; tick();
        valid[0] = 1'b0;
        chk("rmf_count_queued", int'(cnt[0]), 2);
        repeat (16) tick();
        chk("rmf_bit3_low", int'(ser[0]), 0);
        chk("rmf_active", int'(act[0]), 1);
        rst_n[0] = 1'b0;
        #2;
        chk("rmf_serial_async", int'(ser[0]), 1);
        chk("rmf_active_async", int'(act[0]), 0);
        chk("rmf_count_async", int'(cnt[0]), 0);
        chk("rmf_ready_async", int'(ready[0]), 1);
        repeat (3) tick();
        rst_n[0] = 1'b1;
        repeat (100) tick();
        chk("rmf_quiet_serial", int'(ser[0]), 1);
        chk("rmf_quiet_count", int'(cnt[0]), 0);
        valid[0] = 1'b1; tx_byte[0] = 8'h5A;
        tick();
        n = ecount;
        valid[0] = 1'b0;
        expect_frame(0, 8'h5A, n + 2);
        drain(0, 200);

        // Default parameters: 217 clocks per bit
        valid[1] = 1'b1; tx_byte[1] = 8'h73;
        tick();
        n = ecount;
        valid[1] = 1'b0;
        expect_frame(1, 8'h73, n + 2);
        drain(1, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
